// File: rtl/ram16_array.sv
// Single-port 16-bit scratch RAM with registered read data and a
// write-count FULL pulse every DEPTH accepted writes.
module ram16_array #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [15:0]           Di,
    output logic [15:0]           Do,
    output logic                  FULL
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] WCNT_LAST = '1;

    logic [15:0]           mem_q [DEPTH];
    logic [15:0]           mem_d [DEPTH];
    logic [15:0]           do_q;
    logic [15:0]           do_d;
    logic [ADDR_WIDTH-1:0] wcnt_q;
    logic [ADDR_WIDTH-1:0] wcnt_d;
    logic                  full_q;
    logic                  full_d;

    always_comb begin
        mem_d  = mem_q;
        do_d   = do_q;
        wcnt_d = wcnt_q;
        full_d = 1'b0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            do_d   = '0;
            wcnt_d = '0;
        end else begin
            // Read samples mem_q, so a same-edge write returns old data.
            if (READ) begin
                do_d = mem_q[A];
            end
            if (WRITE) begin
                mem_d[A] = Di;
                wcnt_d   = wcnt_q + 1'b1;
                full_d   = (wcnt_q == WCNT_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q  <= mem_d;
        do_q   <= do_d;
        wcnt_q <= wcnt_d;
        full_q <= full_d;
    end

    assign Do   = do_q;
    assign FULL = full_q;

endmodule

// File: tb/tb_ram16_array.sv
// Directed bench for ram16_array: scoreboard of expected read data,
// reference memory/counter model, immediate-assertion checks.
module tb_ram16_array;

    logic        clk;
    logic        rst;
    logic        READ;
    logic        WRITE;
    logic [2:0]  A;
    logic [15:0] Di;
    logic [15:0] Do;
    logic        FULL;

    int total;
    int bad;
    int npulse;

    logic [15:0] m_mem [8];
    logic [2:0]  m_cnt;
    logic [15:0] m_do;
    logic [15:0] sb [$];

    ram16_array #(.ADDR_WIDTH(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .READ (READ),
        .WRITE(WRITE),
        .A    (A),
        .Di   (Di),
        .Do   (Do),
        .FULL (FULL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            rst   = 1'b0;
            READ  = 1'b1;
            WRITE = 1'b1;
            A     = 3'd3;
            Di    = 16'hFFFF;
            @(posedge clk);
            #1;
            chk("rst_do", Do, 16'h0000);
            chk("rst_full", {15'b0, FULL}, 16'h0000);
        end
        for (int k = 0; k < 8; k++) m_mem[k] = '0;
        m_cnt = '0;
        m_do  = '0;
        sb.delete();
        rst   = 1'b1;
        READ  = 1'b0;
        WRITE = 1'b0;
    endtask

    task automatic cyc(input logic rd, input logic wr,
                       input logic [2:0] a, input logic [15:0] di);
        logic exp_full;
        READ  = rd;
        WRITE = wr;
        A     = a;
        Di    = di;
        if (rd) sb.push_back(m_mem[a]);
        exp_full = wr && (m_cnt == 3'd7);
        if (wr) begin
            m_mem[a] = di;
            m_cnt    = m_cnt + 3'd1;
        end
        @(posedge clk);
        #1;
        READ  = 1'b0;
        WRITE = 1'b0;
        chk("full", {15'b0, FULL}, {15'b0, exp_full});
        if (FULL === 1'b1) npulse++;
        if (rd) m_do = sb.pop_front();
        chk("do", Do, m_do);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        npulse = 0;
        rst    = 1'b0;
        READ   = 1'b0;
        WRITE  = 1'b0;
        A      = '0;
        Di     = '0;

        // Reset with strobes asserted, then read back a cleared RAM
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 3'(k), 16'h0);
            chk("clr_rd", Do, 16'h0000);
        end

        // 32 writes with read-back; FULL after writes 8,16,24,32
        npulse = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 1'b1, 3'(i % 8), 16'hB000 + 16'(i));
            cyc(1'b0, 1'b0, 3'(i % 8), 16'h0);
            cyc(1'b1, 1'b0, 3'(i % 8), 16'h0);
            chk("wr_rd", Do, 16'hB000 + 16'(i));
        end
        chk("pulses32", 16'(npulse), 16'd4);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b0, 3'(k), 16'h0);
            chk("final", Do, 16'hB018 + 16'(k));
        end

        // Simultaneous read/write is read-before-write
        cyc(1'b0, 1'b1, 3'd2, 16'h1234);
        cyc(1'b1, 1'b1, 3'd2, 16'hABCD);
        chk("rbw_old", Do, 16'h1234);
        cyc(1'b1, 1'b0, 3'd2, 16'h0);
        chk("rbw_new", Do, 16'hABCD);

        // Do holds while READ is low
        cyc(1'b0, 1'b1, 3'd2, 16'h5555);
        chk("hold0", Do, 16'hABCD);
        cyc(1'b0, 1'b0, 3'd2, 16'h0);
        chk("hold1", Do, 16'hABCD);
        cyc(1'b1, 1'b0, 3'd2, 16'h0);
        chk("hold_rd", Do, 16'h5555);

        // Seven writes never raise FULL
        do_reset(1);
        npulse = 0;
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 3'(i), 16'h7000 + 16'(i));
        cyc(1'b0, 1'b0, 3'd0, 16'h0);
        chk("pulses7", 16'(npulse), 16'd0);

        // Reset mid-count discards partial write count
        do_reset(1);
        npulse = 0;
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 3'(i), 16'h6000 + 16'(i));
        do_reset(1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 3'(i % 4), 16'hC000 + 16'(i));
        chk("pulses_pre8", 16'(npulse), 16'd0);
        cyc(1'b0, 1'b1, 3'd3, 16'hC007);
        chk("pulse8", {15'b0, FULL}, 16'h0001);
        cyc(1'b0, 1'b0, 3'd0, 16'h0);
        chk("pulses_rst", 16'(npulse), 16'd1);
        for (int k = 4; k < 8; k++) begin
            cyc(1'b1, 1'b0, 3'(k), 16'h0);
            chk("rst_clr", Do, 16'h0000);
        end
        cyc(1'b1, 1'b0, 3'd3, 16'h0);
        chk("post_rst", Do, 16'hC007);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram16_array.md
Name: ram16_array

Overview:
- Single-port synchronous RAM of 2^ADDR_WIDTH words, 16 bits each.
- Has a registered read port.
- Has a write-count FULL indicator that pulses once for every DEPTH accepted writes.
- Used as a small scratch/buffer memory behind a simple READ/WRITE strobe interface. There is no handshake back-pressure.

Parameters:
- ADDR_WIDTH, 3, address width in bits. DEPTH = 2^ADDR_WIDTH words (default 8).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- READ  input  1  read strobe; sampled at the rising clk edge.
- WRITE  input  1  write strobe; sampled at the rising clk edge.
- A  input  ADDR_WIDTH  word address for both read and write.
- Di  input  16  write data.
- Do  output  16  registered read data.
- FULL  output  1  registered one-cycle pulse after every DEPTH-th accepted write.

Behaviour:
- Reset (rst low at a rising edge):
  - Do <= 0, FULL <= 0, internal write counter wcnt <= 0.
  - All DEPTH memory words cleared to 16'h0000.
  - Reset has priority over READ and WRITE; a strobe in a reset cycle is ignored.
  - A reset mid-sequence discards any partial write count.
- Write: rst high and WRITE high at an edge -> RAM[A] <= Di. The stored data is visible to a READ issued on any later edge.
- Read: rst high and READ high at an edge -> Do <= RAM[A].
  - Latency is 1 cycle: Do is valid after the edge that sampled READ.
  - Do holds its last value while READ is low; it never returns to 0 except on reset.
- Simultaneous READ and WRITE at the same edge:
  - Both are performed.
  - Read-before-write: Do receives the old contents of RAM[A]; the new Di is stored.
- Write counter wcnt (ADDR_WIDTH bits):
  - Increments by 1 on each accepted write, modulo DEPTH.
  - Independent of A: it counts writes, not distinct addresses.
- FULL:
  - On an accepted write with wcnt == DEPTH-1, FULL <= 1 for exactly the following cycle and wcnt wraps to 0.
  - Every other edge drives FULL <= 0.
  - N accepted writes produce floor(N/DEPTH) FULL pulses; the pulse count is never affected by READ activity.
- Address: A is always in range (full ADDR_WIDTH decode); there is no out-of-range case.
- Idle (no strobes): memory, Do and wcnt are unchanged; FULL = 0.
- No combinational path from inputs to Do or FULL.

Test Plan:
1. Reset
   - Stimulus: rst=0 for 2 edges with READ=1, A=3.
   - Required: Do=0000, FULL=0.
   - Then: rst=1, READ at A=0..7 -> Do=0000 for each.
2. Write/read-back
   - Stimulus: for i=0..31, write Di=B000+i to A=i%8, idle one cycle, READ A.
   - Required: Do=B000+i one cycle after READ.
   - Final contents: RAM[k]=B018+k for k=0..7.
3. FULL count
   - Stimulus: the 32 writes of scenario 2.
   - Required: exactly 4 FULL rising edges, each 1 cycle wide, on the cycles after writes 8, 16, 24 and 32.
   - Also: after 7 writes only, FULL stays 0.
4. Simultaneous access
   - Stimulus: RAM[2]=1234; at one edge, WRITE=1, READ=1, A=2, Di=ABCD.
   - Required: Do=1234 after that edge; a subsequent READ of A=2 gives Do=ABCD.
5. Do hold
   - Stimulus: after reading ABCD, deassert READ and write 5555 to A=2.
   - Required: Do stays ABCD until the next READ.
6. Reset mid-count
   - Stimulus: 5 writes, then a reset, then 8 writes.
   - Required: exactly one FULL pulse, after the 8th post-reset write; all RAM words not rewritten read 0000.
